start_stop_conditioner: RTL and testbench

Synchronous front end for the microwave start/stop control path. Conditions the raw start button, stop button and door switch: synchronises, debounces and edge-detects each input. Drives the `S` and `R` inputs of the downstream `sr_latch` as registered single-cycle pulses. Never asserts both pulses together and never issues a pulse that would not change the latch state.

---
 rtl/start_stop_conditioner.sv | 115 +++++++++++
 tb/tb_start_stop_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/start_stop_conditioner.sv
// start_stop_conditioner
//   Front end for the microwave start/stop control path. Each raw input
//   (start button, stop button, door switch) is synchronised, debounced and
//   edge-detected. The resulting events become registered single-cycle set
//   and reset pulses for the downstream sr_latch.
//
//   Ports
//     clk        system clock, rising-edge
//     rst        synchronous active-high reset
//     start_btn  raw start button (async, active-high)
//     stop_btn   raw stop button (async, active-high)
//     door_open  raw door switch (async, 1 = open)
//     q_fb       Q fed back from sr_latch (synchronous)
//     S, R       set / reset pulses to sr_latch, one cycle wide, never both
//     start_db, stop_db, door_db   debounced levels

// One conditioned input: 2-flop synchroniser, debounce counter, rise detect.
module ssc_channel #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1, sync2;
    logic          prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            prev  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= db;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Level held long enough: adopt it and re-arm the counter.
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Rising edge only, so a held input yields a single event.
    assign rise = db & ~prev;
endmodule

module start_stop_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_btn,
    input  logic stop_btn,
    input  logic door_open,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic start_db,
    output logic stop_db,
    output logic door_db
);
    logic [2:0] raw;
    logic [2:0] db;
    logic [2:0] rise;
    logic       start_ev;
    logic       stop_ev;

    // Channel order: 0 = start, 1 = stop, 2 = door.
    assign raw = {door_open, stop_btn, start_btn};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        ssc_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .db   (db[i]),
            .rise (rise[i])
        );
    end

    assign start_db = db[0];
    assign stop_db  = db[1];
    assign door_db  = db[2];

    // Opening the door is treated exactly like pressing stop.
    assign start_ev = rise[0];
    assign stop_ev  = rise[1] | rise[2];

    // Stop wins; a start that collides with a stop, arrives with the door
    // open, or would not change the latch is dropped outright. Both terms
    // are qualified by opposite polarities of q_fb, so S and R are exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            S <= 1'b0;
            R <= 1'b0;
        end else begin
            R <= stop_ev & q_fb;
            S <= start_ev & ~stop_ev & ~door_db & ~q_fb;
        end
    end
endmodule

// File: tb/tb_start_stop_conditioner.sv
module tb_start_stop_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_btn = 1'b0, stop_btn = 1'b0, door_open = 1'b0, q_fb = 1'b0;
    logic S, R, start_db, stop_db, door_db;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        bit is_r;
    } exp_t;
    exp_t q[$];

    start_stop_conditioner #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .door_open (door_open),
        .q_fb      (q_fb),
        .S         (S),
        .R         (R),
        .start_db  (start_db),
        .stop_db   (stop_db),
        .door_db   (door_db)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Monitor: every pulse seen must match the head of the expected queue.
    always @(negedge clk) begin
        if (S === 1'b1 || R === 1'b1) begin
            checks++;
            if (S && R) begin
                errors++;
                $display("FAIL both_pulses: S=%b R=%b at cycle %0d, required not both", S, R, cyc);
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: S=%b R=%b at cycle %0d, required no pulse", S, R, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.is_r != R) begin
                    errors++;
                    $display("FAIL pulse: got %s at cycle %0d, required %s at cycle %0d",
                             R ? "R" : "S", cyc, e.is_r ? "R" : "S", e.cyc);
                end
            end
        end
    end

    task automatic expect_pulse(input int at, input bit is_r);
        exp_t e;
        e.cyc = at;
        e.is_r = is_r;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic chk_idle(input string name);
        checks++;
        if ({S, R, start_db, stop_db, door_db} !== 5'b0) begin
            errors++;
            $display("FAIL %s: S R start_db stop_db door_db = %b required 00000 at cycle %0d",
                     name, {S, R, start_db, stop_db, door_db}, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge following edge k.
    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        int n;
        // Reset: three reset edges, then four idle cycles.
        repeat (3) begin
            @(negedge clk);
            chk_idle("reset_hold");
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk_idle("reset_release");
        end

        // Start press sampled at edge 10, held 20 cycles.
        wait_to(9);
        start_btn = 1'b1;
        n = cyc + 1;
        expect_pulse(n + 6, 1'b0);
        wait_to(n + 4); chk("start_db_early", start_db, 1'b0);
        wait_to(n + 5); chk("start_db_rise", start_db, 1'b1);
        wait_to(n + 19); start_btn = 1'b0;
        wait_to(n + 32); chk("start_db_release", start_db, 1'b0);

        // Glitch of 3 sampled cycles: rejected.
        start_btn = 1'b1;
        n = cyc + 1;
        wait_to(n + 2); start_btn = 1'b0;
        wait_to(n + 12); chk("glitch3_db", start_db, 1'b0);

        // 4 sampled cycles: accepted.
        start_btn = 1'b1;
        n = cyc + 1;
        expect_pulse(n + 6, 1'b0);
        wait_to(n + 3); start_btn = 1'b0;
        wait_to(n + 5); chk("pulse4_db", start_db, 1'b1);
        wait_to(n + 16); chk("pulse4_release", start_db, 1'b0);

        // Stop priority: start and stop together with q_fb=1.
        q_fb = 1'b1;
        start_btn = 1'b1;
        stop_btn = 1'b1;
        n = cyc + 1;
        expect_pulse(n + 6, 1'b1);
        wait_to(n + 8); start_btn = 1'b0; stop_btn = 1'b0;
        wait_to(n + 20);

        // Door open with q_fb=0: no R; start while door open: no S.
        q_fb = 1'b0;
        door_open = 1'b1;
        n = cyc + 1;
        wait_to(n + 10); chk("door_db_open", door_db, 1'b1);
        start_btn = 1'b1;
        wait_to(n + 18); chk("start_db_door", start_db, 1'b1);
        start_btn = 1'b0;
        wait_to(n + 30); door_open = 1'b0;
        wait_to(n + 42); chk("door_db_closed", door_db, 1'b0);

        // q_fb=1, door opens: one R at n+6.
        q_fb = 1'b1;
        door_open = 1'b1;
        n = cyc + 1;
        expect_pulse(n + 6, 1'b1);
        wait_to(n + 12); door_open = 1'b0;
        wait_to(n + 24);

        // Redundant start with q_fb=1: no S.
        start_btn = 1'b1;
        n = cyc + 1;
        wait_to(n + 8); start_btn = 1'b0;
        wait_to(n + 20);

        // Stop held 50 cycles with q_fb=1: exactly one R.
        stop_btn = 1'b1;
        n = cyc + 1;
        expect_pulse(n + 6, 1'b1);
        wait_to(n + 49); stop_btn = 1'b0;
        wait_to(n + 45); chk("stop_db_held", stop_db, 1'b1);
        wait_to(n + 62); chk("stop_db_release", stop_db, 1'b0);

        // Re-press stop: second R; q_fb drops during the pulse cycle.
        stop_btn = 1'b1;
        n = cyc + 1;
        expect_pulse(n + 6, 1'b1);
        wait_to(n + 6); q_fb = 1'b0;
        wait_to(n + 8); stop_btn = 1'b0;
        wait_to(n + 20);

        // Reset mid-debounce discards the count; held input is a fresh press.
        start_btn = 1'b1;
        n = cyc + 1;
        wait_to(n + 2); rst = 1'b1;
        wait_to(n + 4); rst = 1'b0;
        expect_pulse(n + 11, 1'b0);
        wait_to(n + 5); chk("rst_mid_db", start_db, 1'b0);
        wait_to(n + 10); chk("rst_fresh_db", start_db, 1'b1);
        wait_to(n + 14); start_btn = 1'b0;
        wait_to(n + 30);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d expected pulses outstanding, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
